// File: rtl/fpu_op_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_op_sequencer
//
// Issue-side controller for the floating-point unit. It accepts one FP
// operation code at a time, drives the unit-select address and a one-cycle
// start pulse, and then waits a per-class latency. After that wait it samples
// the selector's registered overflow status and hands it back to the requester.
// Sticky exception flags and a level interrupt are kept for the CSR path.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   op_valid    requester has an operation
//   op_code     4-bit operation code (selector address map)
//   op_ready    sequencer can accept an operation (IDLE only)
//   unit_addr   select address to FP units / overflow selector
//   unit_start  one-cycle start pulse to the selected unit
//   ovf_in      registered overflow status from the selector
//   res_valid   status result available
//   res_ready   requester takes result
//   res_ovf     captured status: bit0 overflow, bit1 underflow
//   flag_clr    clear sticky flags
//   flag_mask   interrupt enable per flag bit
//   sticky      accumulated exception flags
//   irq         level interrupt, |(sticky & flag_mask)
// -----------------------------------------------------------------------------
module fpu_op_sequencer #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8,
  parameter int LAT_CVT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [3:0] op_code,
  output logic       op_ready,
  output logic [3:0] unit_addr,
  output logic       unit_start,
  input  logic [1:0] ovf_in,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_ovf,
  input  logic       flag_clr,
  input  logic [1:0] flag_mask,
  output logic [1:0] sticky,
  output logic       irq
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q;
  logic [1:0]       res_ovf_q;
  logic [1:0]       sticky_q;
  logic [1:0]       cap_status;
  logic             accept;

  // Number of WAIT cycles for the latency class of an operation code.
  function automatic logic [CNT_W-1:0] class_lat(input logic [3:0] code);
    case (code)
      4'b0001, 4'b0010, 4'b0011, 4'b0100: class_lat = CNT_W'(LAT_ADD);
      4'b0101, 4'b0110:                   class_lat = CNT_W'(LAT_MUL);
      4'b0111:                            class_lat = CNT_W'(LAT_DIV);
      default:                            class_lat = CNT_W'(LAT_CVT);
    endcase
  endfunction

  // Ops with no status (0000, lui 1100, 1101) never report an exception,
  // whatever the selector happens to present.
  function automatic logic [1:0] capture_status(input logic [3:0] code,
                                                input logic [1:0] ovf);
    case (code)
      4'b0000, 4'b1100, 4'b1101: capture_status = 2'b00;
      default:                   capture_status = ovf;
    endcase
  endfunction

  // Gated with rst so the requester never sees ready while reset is held.
  assign op_ready   = (state_q == IDLE) && rst;
  assign accept     = op_valid && op_ready;
  assign cap_status = capture_status(code_q, ovf_in);

  // ---- next-state / counter -------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          cnt_d   = class_lat(op_code);
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT: begin
        // Leaving at a count of 1 makes WAIT last exactly the loaded latency.
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: state_d = DONE;
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- outputs decoded from state -------------------------------------------
  always_comb begin
    unit_addr  = 4'h0;
    unit_start = 1'b0;
    res_valid  = 1'b0;
    case (state_q)
      ISSUE: begin
        unit_addr  = code_q;
        unit_start = 1'b1;
      end
      WAIT, CAPTURE: unit_addr = code_q;
      DONE:          res_valid = 1'b1;
      default: ;
    endcase
  end

  // ---- control / status registers -------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      res_ovf_q <= 2'b00;
      sticky_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == CAPTURE) begin
        res_ovf_q <= cap_status;
        // A coincident clear drops old flags but keeps the new capture.
        sticky_q  <= (flag_clr ? 2'b00 : sticky_q) | cap_status;
      end else if (flag_clr) begin
        sticky_q <= 2'b00;
      end
    end
  end

  // ---- latched operation code (data, not reset) ------------------------------
  always_ff @(posedge clk) begin
    if (accept) code_q <= op_code;
  end

  assign res_ovf = res_ovf_q;
  assign sticky  = sticky_q;
  assign irq     = |(sticky_q & flag_mask);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fpu_op_sequencer
//
// Scoreboard bench: the driver issues operations and pushes the expected
// transaction (code, status, latency, accept cycle) into a queue; the monitor
// runs on the falling edge, derives the expected outputs for the in-flight
// transaction from its age, pops it on result handoff, and keeps a model of
// the sticky flags.
// -----------------------------------------------------------------------------
module tb_fpu_op_sequencer;

  localparam int LAT_ADD = 2;
  localparam int LAT_MUL = 3;
  localparam int LAT_DIV = 8;
  localparam int LAT_CVT = 1;
  localparam int CNT_W   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [3:0] op_code;
  logic       op_ready;
  logic [3:0] unit_addr;
  logic       unit_start;
  logic [1:0] ovf_in;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_ovf;
  logic       flag_clr;
  logic [1:0] flag_mask;
  logic [1:0] sticky;
  logic       irq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] code;
    logic [1:0] ovf;
    int         lat;
    int         acc;
  } item_t;

  item_t      q[$];
  logic [1:0] sticky_m = 2'b00;

  fpu_op_sequencer #(
    .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
    .LAT_CVT(LAT_CVT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .unit_addr(unit_addr), .unit_start(unit_start), .ovf_in(ovf_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_ovf(res_ovf),
    .flag_clr(flag_clr), .flag_mask(flag_mask), .sticky(sticky), .irq(irq)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: latency class from the opcode table.
  function automatic int ref_lat(input logic [3:0] c);
    if (c >= 4'd1 && c <= 4'd4) return LAT_ADD;
    if (c == 4'd5 || c == 4'd6) return LAT_MUL;
    if (c == 4'd7)              return LAT_DIV;
    return LAT_CVT;
  endfunction

  // Reference: reported status, zero for the no-status ops.
  function automatic logic [1:0] ref_status(input logic [3:0] c, input logic [1:0] o);
    if (c == 4'd0 || c == 4'd12 || c == 4'd13) return 2'b00;
    return o;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    item_t      it;
    int         d;
    logic [3:0] ea;
    logic       es, ev, er;
    logic [1:0] nxt;
    if (!rst) begin
      check("rst_unit_addr",  8'(unit_addr),  8'h0);
      check("rst_unit_start", 8'(unit_start), 8'h0);
      check("rst_res_valid",  8'(res_valid),  8'h0);
      check("rst_res_ovf",    8'(res_ovf),    8'h0);
      check("rst_sticky",     8'(sticky),     8'h0);
      check("rst_irq",        8'(irq),        8'h0);
      sticky_m = 2'b00;
      q.delete();
    end else begin
      it = '{code: 4'h0, ovf: 2'b00, lat: 0, acc: 0};
      d  = 0;
      ea = 4'h0; es = 1'b0; ev = 1'b0; er = 1'b1;
      if (q.size() != 0) begin
        it = q[0];
        d  = cyc - it.acc;
        er = 1'b0;
        es = (d == 0);
        ea = (d <= it.lat + 1) ? it.code : 4'h0;
        ev = (d >= it.lat + 2);
      end
      check("op_ready",   8'(op_ready),   8'(er));
      check("unit_start", 8'(unit_start), 8'(es));
      check("unit_addr",  8'(unit_addr),  8'(ea));
      check("res_valid",  8'(res_valid),  8'(ev));
      if (ev) check("res_ovf", 8'(res_ovf), 8'(ref_status(it.code, it.ovf)));
      check("sticky", 8'(sticky), 8'(sticky_m));
      check("irq",    8'(irq),    8'(|(sticky_m & flag_mask)));
      nxt = flag_clr ? 2'b00 : sticky_m;
      if (q.size() != 0 && d == it.lat + 1) nxt = nxt | ref_status(it.code, it.ovf);
      sticky_m = nxt;
      if (ev && res_ready) void'(q.pop_front());
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic issue(input logic [3:0] code, input logic [1:0] ovf);
    item_t it;
    int    n;
    n        = 0;
    ovf_in   = ovf;
    op_code  = code;
    op_valid = 1'b1;
    @(negedge clk);
    while (!op_ready) begin
      n++;
      if (n > 200) begin
        $display("FAIL issue: op_ready never rose, got 0 expected 1");
        $fatal(1, "issue timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = 4'($urandom);
    it.code  = code;
    it.ovf   = ovf;
    it.lat   = ref_lat(code);
    it.acc   = cyc;
    q.push_back(it);
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      if (rnd) begin
        res_ready = ($urandom_range(0, 3) != 0);
        flag_clr  = ($urandom_range(0, 15) == 0);
      end
      n++;
    end while (q.size() != 0 && n < 200);
    if (q.size() != 0) begin
      $display("FAIL wait_idle: result pending after 200 cycles, got 1 expected 0");
      $fatal(1, "handoff timeout");
    end
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    op_valid  = 1'b0;
    op_code   = 4'h0;
    ovf_in    = 2'b00;
    res_ready = 1'b1;
    flag_clr  = 1'b0;
    flag_mask = 2'b00;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // add.s, status 01, interrupt on bit0
    flag_mask = 2'b01;
    issue(4'b0001, 2'b01);
    wait_idle(1'b0);

    // div.s with a long result stall and ignored op_valid pulses
    res_ready = 1'b0;
    issue(4'b0111, 2'b10);
    n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      op_valid = i[0];
      op_code  = 4'b0010;
      @(posedge clk);
      #1;
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    wait_idle(1'b0);

    // lui with selector forcing 11: no status reported
    flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    issue(4'b1100, 2'b11);
    wait_idle(1'b0);

    // back-to-back mul.s then sub.s
    flag_mask = 2'b11;
    issue(4'b0101, 2'b10);
    wait_idle(1'b0);
    issue(4'b0011, 2'b01);
    wait_idle(1'b0);

    // clear coinciding with a capture of 01
    issue(4'b0001, 2'b01);
    repeat (LAT_ADD + 1) @(posedge clk);
    #1 flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    wait_idle(1'b0);

    // reset during the WAIT of mul.ps
    issue(4'b0110, 2'b11);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // randomized operations with random back-pressure and clears
    for (int k = 0; k < 40; k++) begin
      flag_mask = 2'($urandom);
      issue(4'($urandom), 2'($urandom));
      wait_idle(1'b1);
    end
    res_ready = 1'b1;
    flag_clr  = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
